// File: rtl/pid_ctrl_param.sv
// rtl/pid_ctrl_param.sv - parametrised PID torque controller with decimated I/D terms and optional slew limit
// Error in, unsigned drive magnitude out; I and D terms update on the decimator tick.
module pid_ctrl_param #(
    parameter int ERR_W    = 13,
    parameter int OUT_W    = 12,
    parameter int INTG_W   = 18,
    parameter int DECIM_W  = 20,
    parameter int D_DEPTH  = 3,
    parameter int D_SAT_W  = 9,
    parameter int I_SHIFT  = 5,
    parameter int D_SHIFT  = 1,
    parameter int SLEW_MAX = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ERR_W-1:0] error,
    input  logic                    not_pedaling,
    input  logic [1:0]              mode,
    output logic                    decim_tick,
    output logic                    int_sat,
    output logic [OUT_W-1:0]        drv_mag
);

    localparam int S_A = (ERR_W > OUT_W + 1) ? ERR_W : OUT_W + 1;
    localparam int S_B = (S_A > D_SAT_W + D_SHIFT + 1) ? S_A : D_SAT_W + D_SHIFT + 1;
    localparam int S   = S_B + 2;

    localparam logic [INTG_W-1:0]    INTG_MAX  = {1'b0, {(INTG_W-1){1'b1}}};
    localparam logic signed [ERR_W:0] D_MAX    = (ERR_W+1)'((1 << (D_SAT_W-1)) - 1);
    localparam logic signed [ERR_W:0] D_MIN    = (ERR_W+1)'(-(1 << (D_SAT_W-1)));
    localparam logic signed [S-1:0]  OUT_MAX_S = S'((1 << OUT_W) - 1);
    localparam logic [OUT_W-1:0]     SLEW      = OUT_W'(SLEW_MAX);

    logic [DECIM_W-1:0]      decim_cnt;
    logic [INTG_W-1:0]       integ;
    logic signed [ERR_W-1:0] hist [D_DEPTH];
    logic signed [S-1:0]     sum_q;

    logic signed [INTG_W:0]  integ_sum;
    logic [INTG_W-1:0]       integ_next;
    logic signed [ERR_W:0]   diff;
    logic signed [D_SAT_W-1:0] d_sat;
    logic [INTG_W-2:0]       i_scaled;
    logic signed [S-1:0]     pterm, iterm, dterm, sum;
    logic [OUT_W-1:0]        target, slew_next;

    assign decim_tick = &decim_cnt;
    assign int_sat    = (integ == INTG_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) decim_cnt <= '0;
        else     decim_cnt <= decim_cnt + 1'b1;
    end

    // integ is never negative, so INTG_W+1 bits hold any single-step sum
    assign integ_sum = $signed({1'b0, integ}) + (INTG_W+1)'(error);

    always_comb begin
        integ_next = integ_sum[INTG_W-1:0];
        if (integ_sum[INTG_W])        integ_next = '0;
        else if (integ_sum[INTG_W-1]) integ_next = INTG_MAX;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              integ <= '0;
        else if (not_pedaling || !mode[1])    integ <= '0;
        else if (decim_tick)                  integ <= integ_next;
    end

    // history keeps shifting in every mode so D is valid the moment PID is selected
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D_DEPTH; i++) hist[i] <= '0;
        end else if (decim_tick) begin
            hist[0] <= error;
            for (int i = 1; i < D_DEPTH; i++) hist[i] <= hist[i-1];
        end
    end

    assign diff = (ERR_W+1)'(error) - (ERR_W+1)'(hist[D_DEPTH-1]);

    always_comb begin
        d_sat = diff[D_SAT_W-1:0];
        if (diff > D_MAX)      d_sat = D_MAX[D_SAT_W-1:0];
        else if (diff < D_MIN) d_sat = D_MIN[D_SAT_W-1:0];
    end

    assign i_scaled = integ[INTG_W-2:0] >> I_SHIFT;

    always_comb begin
        pterm = '0;
        iterm = '0;
        dterm = '0;
        if (mode != 2'b00) pterm = S'(error);
        if (mode[1])       iterm = S'(i_scaled);
        if (mode == 2'b11) dterm = S'(d_sat) <<< D_SHIFT;
        sum = pterm + iterm + dterm;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum;
    end

    always_comb begin
        target = sum_q[OUT_W-1:0];
        if (sum_q[S-1])            target = '0;
        else if (sum_q > OUT_MAX_S) target = '1;
    end

    always_comb begin
        if (target > drv_mag)
            slew_next = (target - drv_mag > SLEW) ? drv_mag + SLEW : target;
        else
            slew_next = (drv_mag - target > SLEW) ? drv_mag - SLEW : target;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  drv_mag <= '0;
        else if (mode == 2'b00 || not_pedaling)   drv_mag <= '0;
        else if (SLEW_MAX == 0)                   drv_mag <= target;
        else if (decim_tick)                      drv_mag <= slew_next;
    end

endmodule

// File: tb/tb_pid_ctrl_param.sv
// tb/tb_pid_ctrl_param.sv - self-checking bench for pid_ctrl_param, unlimited and slew-limited instances
// Integer reference model of the controller; directed scenarios followed by random stimulus.
module tb_pid_ctrl_param;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic signed [12:0] error = '0;
    logic              np = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              tick_a, sat_a, tick_s, sat_s;
    logic [11:0]       drv_a, drv_s;

    int tests = 0;
    int fails = 0;

    int m_cnt, m_integ, m_sum, m_drv_a, m_drv_s;
    int m_hist [3];
    bit m_last_tick;

    localparam int IMAX = 131071;

    always #5 clk = ~clk;

    pid_ctrl_param #(.DECIM_W(4), .SLEW_MAX(0)) dut_a (
        .clk(clk), .rst(rst), .error(error), .not_pedaling(np), .mode(mode),
        .decim_tick(tick_a), .int_sat(sat_a), .drv_mag(drv_a));

    pid_ctrl_param #(.DECIM_W(4), .SLEW_MAX(64)) dut_s (
        .clk(clk), .rst(rst), .error(error), .not_pedaling(np), .mode(mode),
        .decim_tick(tick_s), .int_sat(sat_s), .drv_mag(drv_s));

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_integ = 0; m_sum = 0; m_drv_a = 0; m_drv_s = 0;
        foreach (m_hist[i]) m_hist[i] = 0;
    endtask

    task automatic model_edge();
        int e, md, t, p, i, d, nsum;
        bit tk;
        e  = error;
        md = mode;
        tk = (m_cnt == 15);
        t  = clampi(m_sum, 0, 4095);
        p  = (md != 0) ? e : 0;
        i  = (md >= 2) ? m_integ / 32 : 0;
        d  = (md == 3) ? 2 * clampi(e - m_hist[2], -256, 255) : 0;
        nsum = p + i + d;
        if (np || md < 2) m_integ = 0;
        else if (tk)      m_integ = clampi(m_integ + e, 0, IMAX);
        if (tk) begin
            m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = e;
        end
        if (md == 0 || np) begin
            m_drv_a = 0; m_drv_s = 0;
        end else begin
            m_drv_a = t;
            if (tk) begin
                if (t > m_drv_s) m_drv_s = m_drv_s + ((t - m_drv_s > 64) ? 64 : t - m_drv_s);
                else             m_drv_s = m_drv_s - ((m_drv_s - t > 64) ? 64 : m_drv_s - t);
            end
        end
        m_sum = nsum;
        m_cnt = (m_cnt + 1) % 16;
        m_last_tick = tk;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("drv_a", drv_a, m_drv_a);
        chk("drv_s", drv_s, m_drv_s);
        chk("sat_a", sat_a, int'(m_integ == IMAX));
        chk("sat_s", sat_s, int'(m_integ == IMAX));
        chk("tick_a", tick_a, int'(m_cnt == 15));
        chk("tick_s", tick_s, int'(m_cnt == 15));
    endtask

    task automatic wait_tick_edges(input int n);
        int seen = 0;
        for (int c = 0; c < 20 * n && seen < n; c++) begin
            step();
            if (m_last_tick) seen++;
        end
        chk("tick_wait", seen, n);
    endtask

    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_drv_a"}, drv_a, 0);
        chk({tag, "_drv_s"}, drv_s, 0);
        chk({tag, "_sat"}, sat_a, 0);
        chk({tag, "_tick"}, tick_a, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        int k, ticks;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_drv", drv_a, 0);
        chk("rst_sat", sat_a, 0);
        chk("rst_tick", tick_a, 0);
        #2 rst = 1'b0;

        k = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (tick_a) begin k = c; break; end
        end
        chk("first_tick", k, 15);

        // P-only, two-cycle latency
        mode = 2'b01; error = 13'sd100;
        step(); chk("p_lat1", drv_a, 0);
        step(); chk("p_100", drv_a, 100);
        error = -13'sd50;
        step(); step(); chk("p_neg", drv_a, 0);
        error = 13'sd900;
        step(); step(); chk("p_900", drv_a, 900);
        async_reset("rst_mid");

        // PI integrator saturation
        mode = 2'b10; error = 13'sd4095;
        ticks = 0;
        for (int c = 0; c < 40 * 16; c++) begin
            step();
            if (m_last_tick) ticks++;
            if (sat_a) break;
        end
        chk("sat_tick", ticks, 33);
        step(); step();
        chk("pi_drv", drv_a, 4095);
        chk("pi_sat", sat_a, 1);
        np = 1'b1;
        step();
        chk("np_drv", drv_a, 0);
        chk("np_sat", sat_a, 0);
        np = 1'b0;

        // integrator never goes negative
        error = -13'sd10;
        wait_tick_edges(5);
        chk("neg_sat", sat_a, 0);
        error = '0;
        step(); step();
        chk("neg_integ", drv_a, 0);

        // derivative, positive step
        mode = 2'b11; error = '0;
        wait_tick_edges(3);
        error = 13'sd300;
        step(); step();
        chk("d_pos", drv_a, 810);
        wait_tick_edges(2);
        step(); step();
        chk("d_pos2", drv_a, 828);
        wait_tick_edges(1);
        step(); step();
        chk("d_done", drv_a, 328);

        // derivative, negative step on top of a saturated integrator
        error = 13'sd4095;
        for (int c = 0; c < 40 * 16 && !sat_a; c++) step();
        chk("d_presat", sat_a, 1);
        error = '0;
        wait_tick_edges(3);
        error = -13'sd300;
        step(); step();
        chk("d_neg", drv_a, 3283);
        async_reset("rst_sat");
        chk("rst_sat_model", m_integ, 0);

        // slew limiter
        mode = 2'b00; error = '0;
        step();
        mode = 2'b01;
        wait_tick_edges(1);
        error = 13'sd1000;
        for (int t = 1; t <= 16; t++) begin
            wait_tick_edges(1);
            chk($sformatf("slew_t%0d", t), drv_s, (64 * t > 1000) ? 1000 : 64 * t);
        end
        chk("slew_a", drv_a, 1000);
        mode = 2'b00;
        step();
        chk("slew_off", drv_s, 0);

        // random phase
        for (int c = 0; c < 900; c++) begin
            error = 13'($urandom_range(0, 8191));
            if ($urandom_range(0, 7) == 0) error = 13'($urandom_range(4000, 4095));
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) np = ~np;
            step();
        end
        np = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pid_ctrl_param.md
Name: pid_ctrl_param

Overview:
Parametrised next-generation PID torque controller for the e-bike drive path. It takes the signed torque/cadence error and produces the unsigned motor drive magnitude. Compared with the fixed-width PID it adds:
- parametrised widths, decimation rate, derivative history depth and term gains
- a run-time mode select (off/P/PI/PID)
- an integrator-saturation flag
- an optional per-tick slew-rate limiter on the output
It sits between the error computation and the brushless commutation/PWM stage.

Parameters:
ERR_W, 13, signed error width
OUT_W, 12, unsigned drv_mag width
INTG_W, 18, integrator width (held non-negative)
DECIM_W, 20, decimator counter width; 4 for fast simulation
D_DEPTH, 3, decimated samples back used for derivative (>=1)
D_SAT_W, 9, signed saturation width of derivative difference
I_SHIFT, 5, iterm = integrator[INTG_W-2:0] >> I_SHIFT
D_SHIFT, 1, dterm = saturated diff <<< D_SHIFT
SLEW_MAX, 0, max drv_mag change per decimator tick; 0 = limiter disabled

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
error  in  ERR_W  signed error, sampled every cycle
not_pedaling  in  1  rider not pedaling; forces integrator and output to 0
mode  in  2  00 off, 01 P, 10 PI, 11 PID
decim_tick  out  1  high one cycle when decimator counter is all ones
int_sat  out  1  integrator at positive limit
drv_mag  out  OUT_W  registered drive magnitude

Behaviour:
- Clocking/reset: one clock domain, clk. rst is asynchronous, active-high. It clears every register immediately, including mid-operation: counter, integrator, history, sum register and drv_mag. After reset, drv_mag=0, int_sat=0 and decim_tick=0.
- Decimator:
  - Free-running DECIM_W-bit counter that wraps.
  - decim_tick = &counter. The first tick comes 2^DECIM_W-1 cycles after reset release.
- Integrator (INTG_W bits):
  - When not_pedaling=1 or mode<10, it is cleared to 0 every cycle. This has priority over a tick.
  - Otherwise, on a tick: sum = integ + sext(error), computed at INTG_W+1 bits.
  - sum<0 gives 0. sum>2^(INTG_W-1)-1 gives 2^(INTG_W-1)-1. Otherwise it takes sum.
  - Between ticks it holds.
  - int_sat = (integ == 2^(INTG_W-1)-1).
- Derivative:
  - History is a D_DEPTH-entry shift register. On every tick error shifts in, regardless of mode or not_pedaling.
  - prev = oldest entry.
  - diff = error - prev at ERR_W+1 bits, signed-saturated to D_SAT_W bits: max 2^(D_SAT_W-1)-1, min -2^(D_SAT_W-1).
  - dterm = sat << D_SHIFT. dterm=0 unless mode=11.
- Terms:
  - pterm = sext(error) when mode!=00, else 0.
  - iterm = integrator term when mode>=10, else 0.
  - Signed sum is formed at width S = max(ERR_W, OUT_W+1, D_SAT_W+D_SHIFT+1)+2, so the sum itself never overflows.
  - The sum is registered every cycle (stage 1).
- Clamp: target = 0 if sum<0; 2^OUT_W-1 if sum>2^OUT_W-1; else sum[OUT_W-1:0].
- Output stage (stage 2):
  - If mode=00 or not_pedaling=1, drv_mag<=0 on the next edge. This overrides the slew limiter.
  - Else if SLEW_MAX=0, drv_mag<=target every cycle. Latency from error to drv_mag is 2 cycles.
  - Else, on a tick only, drv_mag moves toward target by min(|target-drv_mag|, SLEW_MAX), never overshooting. Between ticks it holds.
- Simultaneous events:
  - A tick together with not_pedaling: the integrator clears and the history still shifts.
  - A mode change takes effect on the sum register at the next edge.

Test Plan:
- Reset: rst asserted mid-run with drv_mag=900 -> drv_mag=0 and int_sat=0 asynchronously. With DECIM_W=4, the first decim_tick comes 15 cycles after release.
- P-only (mode=01, SLEW_MAX=0): error=+100 -> drv_mag=100 two cycles later. error=-50 -> drv_mag=0.
- PI saturation (mode=10, DECIM_W=4, INTG_W=18): error=+4095 held:
  - The integrator rises 4095 per tick and clamps to 131071 on tick 33. int_sat=1.
  - iterm=4095 and drv_mag=4095.
  - Then not_pedaling=1 -> integrator=0 and drv_mag=0 next cycle.
- Negative clamp (mode=10): integrator=0, error=-10 for 5 ticks -> integrator stays 0 and int_sat=0.
- Derivative (mode=11, D_DEPTH=3, D_SAT_W=9, D_SHIFT=1):
  - error steps 0 -> +300 -> dterm contributes +510 until the third tick after the step, then 0.
  - A step 0 -> -300 gives -512.
- Slew (SLEW_MAX=64, mode=01): error 0 -> 1000 -> drv_mag reads 64, 128, ... after successive ticks and reaches 1000 on tick 16.
  - Then mode=00 -> drv_mag=0 on the next edge.
